// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave memory block.
//   spi_slv_state_e   : frame-level FSM states
//   CMD_RW_BIT        : bit of the command byte that selects write (1) / read (0)
//   SPI_BITS_PER_BYTE : bits per serial byte
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    WR   = 2'd2,
    RD   = 2'd3
  } spi_slv_state_e;

  localparam int unsigned CMD_RW_BIT        = 7;
  localparam int unsigned SPI_BITS_PER_BYTE = 8;

endpackage

// File: rtl/spi_edge_sync.sv
// Synchronizer plus edge detector for one asynchronous SPI pin.
//   clk_i    : system clock
//   areset_i : asynchronous active-high reset
//   d_i      : asynchronous input pin
//   rise_o   : one-cycle pulse on a synchronized 0->1 transition
//   fall_o   : one-cycle pulse on a synchronized 1->0 transition
module spi_edge_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk_i,
  input  logic areset_i,
  input  logic d_i,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;
  logic              prev_q;
  logic              sync_s;

  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = d_i;
    for (int unsigned i = 1; i < STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  always_ff @(posedge clk_i or posedge areset_i) begin
    if (areset_i) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= sync_s;
    end
  end

  assign sync_s = sync_q[STAGES-1];
  assign rise_o = sync_s & ~prev_q;
  assign fall_o = ~sync_s & prev_q;

endmodule

// File: rtl/spi_slave_mem.sv
// SPI mode-0 slave with a small byte-wide register file.
// First byte of a frame is {rw, addr}; following bytes are written to
// (rw=1) or read from (rw=0) consecutive addresses, wrapping at DEPTH.
//   clk_i, areset_i : system clock, asynchronous active-high reset
//   sclk_i, cs_n_i, mosi_i : SPI pins from master (oversampled)
//   miso_o, miso_oe_o      : serial data to master and its output enable
//   wr_strobe_o, wr_addr_o, wr_data_o : one-cycle notification of each committed write
//   busy_o                 : frame in progress
module spi_slave_mem #(
  parameter  int unsigned DEPTH       = 16,
  parameter  int unsigned SYNC_STAGES = 2,
  localparam int unsigned AW          = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          areset_i,
  input  logic          sclk_i,
  input  logic          cs_n_i,
  input  logic          mosi_i,
  output logic          miso_o,
  output logic          miso_oe_o,
  output logic          wr_strobe_o,
  output logic [AW-1:0] wr_addr_o,
  output logic [7:0]    wr_data_o,
  output logic          busy_o
);

  import spi_pkg::*;

  logic sclk_rise, sclk_fall, cs_rise, cs_fall;

  spi_edge_sync #(.STAGES(SYNC_STAGES)) u_sclk_sync (
    .clk_i    (clk_i),
    .areset_i (areset_i),
    .d_i      (sclk_i),
    .rise_o   (sclk_rise),
    .fall_o   (sclk_fall)
  );

  spi_edge_sync #(.STAGES(SYNC_STAGES)) u_cs_sync (
    .clk_i    (clk_i),
    .areset_i (areset_i),
    .d_i      (cs_n_i),
    .rise_o   (cs_rise),
    .fall_o   (cs_fall)
  );

  // Same depth as the edge detectors so mosi lines up with the detected sclk rise.
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   mosi_s;

  always_comb begin
    mosi_sync_d    = mosi_sync_q;
    mosi_sync_d[0] = mosi_i;
    for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
      mosi_sync_d[i] = mosi_sync_q[i-1];
    end
  end

  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  spi_slv_state_e state_q, state_d;
  logic [2:0]     bitcnt_q, bitcnt_d;
  logic [7:0]     rx_q, rx_d;
  logic [7:0]     tx_q, tx_d;
  logic [AW-1:0]  addr_q, addr_d;
  logic           miso_q, miso_d;
  logic           strobe_q, strobe_d;
  logic [AW-1:0]  wr_addr_q, wr_addr_d;
  logic [7:0]     wr_data_q, wr_data_d;
  logic [7:0]     mem_q [DEPTH];
  logic           mem_we;
  logic [7:0]     rx_byte;
  logic           last_bit;
  logic [AW-1:0]  addr_inc;

  assign rx_byte  = {rx_q[6:0], mosi_s};
  assign last_bit = sclk_rise && (bitcnt_q == 3'(SPI_BITS_PER_BYTE - 1));
  assign addr_inc = addr_q + AW'(1);

  always_comb begin
    state_d   = state_q;
    bitcnt_d  = bitcnt_q;
    rx_d      = rx_q;
    tx_d      = tx_q;
    addr_d    = addr_q;
    miso_d    = miso_q;
    strobe_d  = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    mem_we    = 1'b0;

    unique case (state_q)
      IDLE: begin
        miso_d = 1'b0;
        if (cs_fall) begin
          state_d  = CMD;
          bitcnt_d = '0;
        end
      end
      CMD: begin
        if (sclk_rise) begin
          rx_d     = rx_byte;
          bitcnt_d = bitcnt_q + 3'd1;
          if (last_bit) begin
            addr_d = rx_byte[AW-1:0];
            if (rx_byte[CMD_RW_BIT]) begin
              state_d = WR;
            end else begin
              state_d = RD;
              tx_d    = mem_q[rx_byte[AW-1:0]];
            end
          end
        end
      end
      WR: begin
        if (sclk_rise) begin
          rx_d     = rx_byte;
          bitcnt_d = bitcnt_q + 3'd1;
          if (last_bit) begin
            mem_we    = 1'b1;
            strobe_d  = 1'b1;
            wr_addr_d = addr_q;
            wr_data_d = rx_byte;
            addr_d    = addr_inc;
          end
        end
      end
      RD: begin
        if (sclk_rise) begin
          bitcnt_d = bitcnt_q + 3'd1;
          if (last_bit) begin
            addr_d = addr_inc;
            tx_d   = mem_q[addr_inc];
          end
        end
        // Presenting tx[7] then shifting on every fall is equivalent to
        // "MSB at first fall, shift on each later fall", including after a reload.
        if (sclk_fall) begin
          miso_d = tx_q[7];
          tx_d   = {tx_q[6:0], 1'b0};
        end
      end
      default: state_d = IDLE;
    endcase

    // Evaluated after the byte logic so a byte completing on the same clk still commits.
    if (state_q != IDLE && cs_rise) begin
      state_d = IDLE;
      miso_d  = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge areset_i) begin
    if (areset_i) begin
      mosi_sync_q <= '0;
      state_q     <= IDLE;
      bitcnt_q    <= '0;
      rx_q        <= '0;
      tx_q        <= '0;
      addr_q      <= '0;
      miso_q      <= 1'b0;
      strobe_q    <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
    end else begin
      mosi_sync_q <= mosi_sync_d;
      state_q     <= state_d;
      bitcnt_q    <= bitcnt_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      addr_q      <= addr_d;
      miso_q      <= miso_d;
      strobe_q    <= strobe_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
    end
  end

  always_ff @(posedge clk_i or posedge areset_i) begin
    if (areset_i) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (mem_we) begin
      mem_q[addr_q] <= rx_byte;
    end
  end

  assign miso_o      = miso_q;
  assign miso_oe_o   = (state_q != IDLE);
  assign busy_o      = (state_q != IDLE);
  assign wr_strobe_o = strobe_q;
  assign wr_addr_o   = wr_addr_q;
  assign wr_data_o   = wr_data_q;

endmodule

// File: tb/tb_spi_slave_mem.sv
module tb_spi_slave_mem;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = 4;
  localparam int unsigned HALF  = 4;

  logic          clk = 1'b0;
  logic          areset = 1'b1;
  logic          sclk = 1'b0;
  logic          cs_n = 1'b1;
  logic          mosi = 1'b0;
  logic          miso_o, miso_oe_o, wr_strobe_o, busy_o;
  logic [AW-1:0] wr_addr_o;
  logic [7:0]    wr_data_o;

  int checks = 0;
  int errors = 0;

  logic [7:0]  model_mem [DEPTH];
  logic [15:0] exp_wr [$];
  logic [15:0] obs_wr [$];
  logic [7:0]  frame_data [$];

  spi_slave_mem #(.DEPTH(DEPTH), .SYNC_STAGES(2)) dut (
    .clk_i       (clk),
    .areset_i    (areset),
    .sclk_i      (sclk),
    .cs_n_i      (cs_n),
    .mosi_i      (mosi),
    .miso_o      (miso_o),
    .miso_oe_o   (miso_oe_o),
    .wr_strobe_o (wr_strobe_o),
    .wr_addr_o   (wr_addr_o),
    .wr_data_o   (wr_data_o),
    .busy_o      (busy_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_strobe_o === 1'b1) obs_wr.push_back({8'(wr_addr_o), wr_data_o});
  end

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 8'h00;
  endtask

  // Master side of one mode-0 byte (or its first nbits bits), MSB first.
  task automatic spi_byte(input logic [7:0] tx, input int unsigned nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int unsigned i = 0; i < nbits; i++) begin
      mosi = tx[3'(7 - i)];
      repeat (HALF) @(negedge clk);
      rx = {rx[6:0], miso_o};
      sclk = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if (miso_o !== rx[0]) begin
        errors++;
        $display("FAIL miso_stable_at_rise: got %b expected %b", miso_o, rx[0]);
      end
      repeat (HALF - 2) @(negedge clk);
      sclk = 1'b0;
    end
  endtask

  task automatic check_strobes(input string name);
    checks++;
    if (obs_wr.size() != exp_wr.size()) begin
      errors++;
      $display("FAIL %s_strobe_count: got %0d expected %0d", name, obs_wr.size(), exp_wr.size());
    end else begin
      for (int k = 0; k < exp_wr.size(); k++) begin
        checks++;
        if (obs_wr[k] !== exp_wr[k]) begin
          errors++;
          $display("FAIL %s_strobe[%0d]: got addr/data %h expected %h", name, k, obs_wr[k], exp_wr[k]);
        end
      end
    end
    obs_wr.delete();
    exp_wr.delete();
  endtask

  // Sends cmd, then every byte in frame_data, then an optional partial byte.
  task automatic run_frame(input string name, input logic [7:0] cmd,
                           input int unsigned partial_bits, input logic [7:0] partial);
    logic [7:0] rx, expb;
    int addr;
    cs_n = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (busy_o !== 1'b1 || miso_oe_o !== 1'b1) begin
      errors++;
      $display("FAIL %s_busy_in_frame: got busy=%b oe=%b expected 1/1", name, busy_o, miso_oe_o);
    end
    spi_byte(cmd, 8, rx);
    checks++;
    if (rx !== 8'h00) begin
      errors++;
      $display("FAIL %s_cmd_miso: got %h expected 00", name, rx);
    end
    addr = int'(cmd[6:0]) % DEPTH;
    foreach (frame_data[k]) begin
      expb = model_mem[addr];
      if (cmd[7]) begin
        model_mem[addr] = frame_data[k];
        exp_wr.push_back({8'(addr), frame_data[k]});
      end
      spi_byte(frame_data[k], 8, rx);
      if (!cmd[7]) begin
        checks++;
        if (rx !== expb) begin
          errors++;
          $display("FAIL %s_read[%0d]: got %h expected %h (addr %0d)", name, k, rx, expb, addr);
        end
      end
      addr = (addr + 1) % DEPTH;
    end
    if (partial_bits > 0) spi_byte(partial, partial_bits, rx);
    repeat (HALF) @(negedge clk);
    cs_n = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (busy_o !== 1'b0 || miso_oe_o !== 1'b0 || miso_o !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle_after_frame: got busy=%b oe=%b miso=%b expected 0/0/0",
               name, busy_o, miso_oe_o, miso_o);
    end
    check_strobes(name);
    frame_data.delete();
  endtask

  task automatic read_all(input string name);
    for (int i = 0; i < DEPTH; i++) frame_data.push_back(8'($urandom));
    run_frame(name, 8'h00, 0, 8'h00);
  endtask

  task automatic test_reset();
    logic [7:0] rx;
    checks++;
    if (miso_o !== 0 || miso_oe_o !== 0 || busy_o !== 0 || wr_strobe_o !== 0 ||
        wr_addr_o !== '0 || wr_data_o !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs: got miso=%b oe=%b busy=%b strobe=%b addr=%h data=%h expected zeros",
               miso_o, miso_oe_o, busy_o, wr_strobe_o, wr_addr_o, wr_data_o);
    end
    frame_data = '{8'h12, 8'h34, 8'h56};
    run_frame("reset_prefill", 8'h87, 0, 8'h00);
    frame_data = '{8'h00, 8'h00};
    run_frame("reset_prefill_rd", 8'h07, 0, 8'h00);
    // Open a read frame so miso/oe/busy are active, then reset mid-clock.
    cs_n = 1'b0;
    repeat (4) @(negedge clk);
    spi_byte(8'h08, 8, rx);
    spi_byte(8'h00, 3, rx);
    @(posedge clk);
    #2 areset = 1'b1;
    #1;
    checks++;
    if (miso_o !== 0 || miso_oe_o !== 0 || busy_o !== 0 || wr_strobe_o !== 0) begin
      errors++;
      $display("FAIL reset_async: got miso=%b oe=%b busy=%b strobe=%b expected 0/0/0/0",
               miso_o, miso_oe_o, busy_o, wr_strobe_o);
    end
    @(negedge clk);
    areset = 1'b0;
    model_clear();
    obs_wr.delete();
    cs_n = 1'b1;
    repeat (4) @(negedge clk);
    read_all("reset_mem_clear");
  endtask

  task automatic test_write_burst();
    frame_data = '{8'hA5, 8'h5A, 8'hFF};
    run_frame("burst_wr", 8'h83, 0, 8'h00);
    frame_data = '{8'h00, 8'h00, 8'h00};
    run_frame("burst_rd", 8'h03, 0, 8'h00);
  endtask

  task automatic test_wrap();
    frame_data = '{8'h11, 8'h22};
    run_frame("wrap_wr", 8'h8F, 0, 8'h00);
    frame_data = '{8'h00, 8'h00};
    run_frame("wrap_rd", 8'h0F, 0, 8'h00);
  endtask

  task automatic test_abort();
    run_frame("abort", 8'h82, 5, 8'hC3);
    frame_data = '{8'h9C, 8'h00};
    run_frame("abort_next", 8'h82, 0, 8'h00);
    frame_data = '{8'h00, 8'h00, 8'h00};
    run_frame("abort_rd", 8'h01, 0, 8'h00);
  endtask

  task automatic test_reset_midframe();
    logic [7:0] rx;
    cs_n = 1'b0;
    repeat (4) @(negedge clk);
    spi_byte(8'h84, 8, rx);
    spi_byte(8'hE7, 1, rx);
    mosi = 1'b1;
    repeat (HALF) @(negedge clk);
    sclk = 1'b1;
    @(posedge clk);
    #2 areset = 1'b1;
    #1;
    checks++;
    if (busy_o !== 0 || miso_oe_o !== 0) begin
      errors++;
      $display("FAIL midreset_busy: got busy=%b oe=%b expected 0/0", busy_o, miso_oe_o);
    end
    @(negedge clk);
    areset = 1'b0;
    model_clear();
    obs_wr.delete();
    repeat (HALF - 1) @(negedge clk);
    sclk = 1'b0;
    // Remaining bits plus a whole byte: cs never re-fell, so nothing decodes.
    spi_byte(8'hA0, 6, rx);
    spi_byte(8'h81, 8, rx);
    repeat (HALF) @(negedge clk);
    checks++;
    if (busy_o !== 0) begin
      errors++;
      $display("FAIL midreset_no_resume: got busy=%b expected 0", busy_o);
    end
    cs_n = 1'b1;
    repeat (4) @(negedge clk);
    check_strobes("midreset_quiet");
    frame_data = '{8'h3C};
    run_frame("midreset_next", 8'h85, 0, 8'h00);
    read_all("midreset_mem");
  endtask

  task automatic test_back_to_back();
    logic [7:0] cmd;
    int unsigned n;
    for (int f = 0; f < 24; f++) begin
      cmd = 8'($urandom);
      n = $urandom_range(0, 4);
      for (int unsigned k = 0; k < n; k++) frame_data.push_back(8'($urandom));
      run_frame("b2b", cmd, 0, 8'h00);
    end
    read_all("b2b_final");
  endtask

  initial begin
    model_clear();
    repeat (3) @(negedge clk);
    areset = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    test_write_burst();
    test_wrap();
    test_abort();
    test_reset_midframe();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_slave_mem.md
Name: spi_slave_mem

Overview:
- Synthesizable SPI slave with a small register-file memory, sitting directly downstream of the APB-programmed SPI master.
- Consumes the master's sclk/cs/mosi outputs and returns miso, so the master's full write/read transaction path can be closed in simulation and on FPGA.
- Oversamples SPI pins in the system clock domain; SPI mode 0 (CPOL=0, CPHA=0), MSB first.

Parameters:
DEPTH, 16, number of 8-bit memory locations; power of two, 2..128
AW, $clog2(DEPTH), memory address width (derived, not overridable)
SYNC_STAGES, 2, synchronizer flops on sclk_i/cs_n_i/mosi_i

Ports:
clk_i  in  1  system clock
areset_i  in  1  asynchronous, active-high reset
sclk_i  in  1  SPI clock from master (idle low)
cs_n_i  in  1  chip select, active low
mosi_i  in  1  serial data from master
miso_o  out  1  serial data to master
miso_oe_o  out  1  high while cs asserted (tri-state enable for board use)
wr_strobe_o  out  1  one-cycle pulse per committed write
wr_addr_o  out  AW  address of committed write
wr_data_o  out  8  data of committed write
busy_o  out  1  high from cs assertion to cs deassertion (synchronized)

Behaviour:
- One clock, clk_i. Reset is asynchronous and active-high on areset_i. Every register and every output reset to 0; memory clears to 0x00; state = IDLE.
- Input conditioning: sclk_i, cs_n_i and mosi_i each pass SYNC_STAGES flops. sclk rise/fall detected from the last two synchronized samples. Detection latency is SYNC_STAGES+1 clk. Requirement: sclk half-period >= 4 clk_i.
- Frame: cs_n falling starts a frame. Byte 0 is the command {rw, addr[6:0]}: rw=1 is write, rw=0 is read. Only addr[AW-1:0] is used; upper bits are ignored.
- Bits are sampled on detected sclk rise and shifted MSB first. A 3-bit bit counter wraps 7->0 at each byte boundary.
- FSM:
  - IDLE: cs_n=1, miso_o=0, oe=0. Synchronized cs_n fall -> CMD, bit counter=0.
  - CMD: after the 8th rise, latch rw and addr. rw=1 -> WR. rw=0 -> RD, and load tx shift register with mem[addr].
  - WR: on each 8th rise, mem[addr]<=rx byte. wr_strobe_o pulses 1 clk with wr_addr_o/wr_data_o valid. Then addr<=addr+1 mod DEPTH.
  - RD: miso_o=tx[7] from the first detected sclk fall after entering RD. Shift left on each subsequent fall. After the 8th rise of each data byte, addr<=addr+1 mod DEPTH and tx<=mem[new addr]; the MSB is presented at the following fall. mosi is ignored in RD.
  - Any state: synchronized cs_n rise -> IDLE next clk. A partial byte is discarded: no write, no strobe. miso_o=0, oe=0.
- Address wraps DEPTH-1 -> 0 in both WR and RD. An unlimited number of data bytes per frame is allowed.
- A cs rise on the same clk as an 8th-bit sclk rise: the completed byte is committed first, then IDLE.
- A frame containing only a command byte has no side effects.
- miso_o changes only on detected sclk fall, or on entry to IDLE.
- busy_o = (state != IDLE).
- Reset asserted mid-frame: immediate return to reset values. The frame is not resumed after reset release until a fresh cs_n fall.
- Memory write port: one write per byte. There is no external read/write port beyond the strobe outputs.

Decomposition:
- Package spi_pkg:
  - state enum spi_slv_state_e {IDLE, CMD, WR, RD}
  - CMD_RW_BIT=7
  - SPI_BITS_PER_BYTE=8
- Sub-module spi_edge_sync: parameterized synchronizer plus rise/fall detector, instantiated for sclk and cs_n. mosi uses its plain synchronizer output, aligned to the same depth.
- Memory stays inline as a flop array (DEPTH<=128).

Test Plan:
- Reset check: assert areset_i mid-clock -> miso_o=0, oe=0, busy_o=0, wr_strobe_o=0 immediately, all memory 0x00.
- Write burst: cs low, send 0x83, 0xA5, 0x5A, 0xFF -> three wr_strobe_o pulses with (3,0xA5), (4,0x5A), (5,0xFF); then read 0x03 with 3 dummy bytes -> miso returns A5 5A FF.
- Wrap: DEPTH=16, write 0x8F, 0x11, 0x22 -> mem[15]=0x11, mem[0]=0x22; read 0x0F for 2 bytes -> 11 22.
- Abort: write 0x82 then 5 bits of 0xC3, cs high -> no strobe, mem[2] unchanged. Next frame proceeds normally from IDLE.
- Reset mid-frame: during the 2nd data bit of a write, pulse areset_i -> memory cleared, busy_o=0. A subsequent frame decodes its first byte as a command.
- Edge timing: sclk half-period = 4 clk, mixed read/write frames back-to-back with cs high for 4 clk between them -> all data matches, miso stable at every sclk rise.
